// File: rtl/frac_lut_pkg.sv
// Shared types and field-offset helpers for the fracturable LUT-K cell.
// No ports; imported by frac_lut_cfg_chain and frac_lut_k_cell.
package frac_lut_pkg;

    typedef enum logic [1:0] {
        UNCONF     = 2'd0,
        LOADING    = 2'd1,
        CONFIGURED = 2'd2,
        ERROR      = 2'd3
    } cfg_state_e;

    // Chain length: LUT mask + mode bit + two reg_sel bits.
    function automatic int cfg_bits(input int k);
        return (1 << k) + 3;
    endfunction

    function automatic int mode_idx(input int k);
        return 1 << k;
    endfunction

    function automatic int reg_sel_idx(input int k, input int n);
        return (1 << k) + 1 + n;
    endfunction

endpackage

// File: rtl/frac_lut_cfg_chain.sv
// Scan-loaded configuration chain with bit counter and load-status FSM.
// Ports:
//   prog_clk_i   clock
//   pReset_i     synchronous active-high reset
//   ccff_en_i    shift enable
//   ccff_head_i  serial data in (lands in cfg[0])
//   cfg_o        parallel configuration bits
//   state_o      current load state
//   ccff_tail_o  serial data out, cfg[CFG_BITS-1]
//   cfg_done_o   registered: state is CONFIGURED
//   cfg_err_o    registered: state is ERROR (sticky until reset)
//
// state      | meaning
// -----------+--------------------------------------------------
// UNCONF     | after reset, no bit shifted yet
// LOADING    | some bits shifted, fewer than CFG_BITS
// CONFIGURED | exactly CFG_BITS bits shifted, cell is live
// ERROR      | shifted past CFG_BITS, held until reset
module frac_lut_cfg_chain
    import frac_lut_pkg::*;
#(
    parameter int K = 4,
    localparam int CFG_BITS = cfg_bits(K)
) (
    input  logic                prog_clk_i,
    input  logic                pReset_i,
    input  logic                ccff_en_i,
    input  logic                ccff_head_i,
    output logic [CFG_BITS-1:0] cfg_o,
    output cfg_state_e          state_o,
    output logic                ccff_tail_o,
    output logic                cfg_done_o,
    output logic                cfg_err_o
);

    localparam int CNT_W = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cfg_state_e          state_q, state_d;
    logic                done_q, err_q;

    always_comb begin
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (ccff_en_i) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head_i};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                UNCONF:     state_d = LOADING;
                // The shift that brings the count to CFG_BITS completes the load.
                LOADING:    state_d = (cnt_q == CNT_LAST) ? CONFIGURED : LOADING;
                CONFIGURED: state_d = ERROR;
                ERROR:      state_d = ERROR;
                default:    state_d = ERROR;
            endcase
        end
    end

    always_ff @(posedge prog_clk_i) begin
        if (pReset_i) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            state_q <= UNCONF;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= (state_d == CONFIGURED);
            err_q   <= (state_d == ERROR);
        end
    end

    assign cfg_o       = cfg_q;
    assign state_o     = state_q;
    assign ccff_tail_o = cfg_q[CFG_BITS-1];
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;

endmodule

// File: rtl/frac_lut_k_cell.sv
// Fracturable LUT-K logic cell: config chain, LUT decode, optional output flops.
// Ports:
//   prog_clk        clock for chain and output flops
//   pReset          synchronous active-high reset
//   ccff_en         config shift enable
//   ccff_head       serial config in
//   frac_logic_in   LUT inputs, bit 0 = mask index LSB
//   ff_en           output flop capture enable
//   frac_logic_out  two logic outputs (combinational or registered per reg_sel)
//   ccff_tail       serial config out
//   cfg_done        cell fully configured
//   cfg_err         sticky over-shift flag
module frac_lut_k_cell
    import frac_lut_pkg::*;
#(
    parameter int K = 4
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         ccff_en,
    input  logic         ccff_head,
    input  logic [K-1:0] frac_logic_in,
    input  logic         ff_en,
    output logic [1:0]   frac_logic_out,
    output logic         ccff_tail,
    output logic         cfg_done,
    output logic         cfg_err
);

    localparam int CFG_BITS = cfg_bits(K);
    localparam int MASK_W   = 1 << K;

    if (K < 3 || K > 8) begin : g_bad_k
        $error("frac_lut_k_cell: K must be in 3..8");
    end

    logic [CFG_BITS-1:0] cfg;
    cfg_state_e          state;

    frac_lut_cfg_chain #(.K(K)) u_chain (
        .prog_clk_i  (prog_clk),
        .pReset_i    (pReset),
        .ccff_en_i   (ccff_en),
        .ccff_head_i (ccff_head),
        .cfg_o       (cfg),
        .state_o     (state),
        .ccff_tail_o (ccff_tail),
        .cfg_done_o  (cfg_done),
        .cfg_err_o   (cfg_err)
    );

    logic [MASK_W-1:0] mask;
    logic              mode;
    logic [1:0]        reg_sel;
    logic [K-2:0]      idx_lo;
    logic              lo, hi, lutk, live;
    logic [1:0]        c;
    logic [1:0]        r_q, r_d;

    assign mask       = cfg[MASK_W-1:0];
    assign mode       = cfg[mode_idx(K)];
    assign reg_sel[0] = cfg[reg_sel_idx(K, 0)];
    assign reg_sel[1] = cfg[reg_sel_idx(K, 1)];
    assign live       = (state == CONFIGURED);

    // lo/hi are the two half-LUTs sharing the low K-1 inputs; the top input
    // only steers the full-width function, so hi ignores it.
    assign idx_lo = frac_logic_in[K-2:0];
    assign lo     = mask[{1'b0, idx_lo}];
    assign hi     = mask[{1'b1, idx_lo}];
    assign lutk   = frac_logic_in[K-1] ? hi : lo;
    assign c      = {hi, (mode ? lo : lutk)};

    always_comb begin
        r_d = r_q;
        if (!live) begin
            r_d = '0;
        end else if (ff_en) begin
            r_d = c;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        frac_logic_out = '0;
        if (live) begin
            frac_logic_out[0] = reg_sel[0] ? r_q[0] : c[0];
            frac_logic_out[1] = reg_sel[1] ? r_q[1] : c[1];
        end
    end

endmodule

// File: tb/tb_frac_lut_k_cell.sv
module tb_frac_lut_k_cell;

    localparam int K = 4;
    localparam int CB = 19;

    logic          prog_clk = 1'b0;
    logic          pReset = 1'b0;
    logic          ccff_en = 1'b0;
    logic          ccff_head = 1'b0;
    logic [K-1:0]  frac_logic_in = '0;
    logic          ff_en = 1'b0;
    logic [1:0]    frac_logic_out;
    logic          ccff_tail;
    logic          cfg_done;
    logic          cfg_err;

    frac_lut_k_cell #(.K(K)) dut (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .ccff_en        (ccff_en),
        .ccff_head      (ccff_head),
        .frac_logic_in  (frac_logic_in),
        .ff_en          (ff_en),
        .frac_logic_out (frac_logic_out),
        .ccff_tail      (ccff_tail),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [1:0] out;
        logic       done;
        logic       err;
        logic       tail;
    } exp_t;

    typedef struct {
        logic [CB-1:0] cfg;   // {reg_sel1, reg_sel0, mode, mask[15:0]}
        logic [K-1:0]  in;
        logic [1:0]    out;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    localparam logic [CB-1:0] AND4    = {3'b000, 16'h8000};
    localparam logic [CB-1:0] AND4_R  = {3'b110, 16'h8000};

    task automatic push(input logic [1:0] o, input logic d, input logic e, input logic t);
        exp_t x;
        x.out = o; x.done = d; x.err = e; x.tail = t;
        sb.push_back(x);
    endtask

    task automatic check_pop(input string nm);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty when output sampled", nm);
            return;
        end
        x = sb.pop_front();
        if (frac_logic_out !== x.out || cfg_done !== x.done ||
            cfg_err !== x.err || ccff_tail !== x.tail) begin
            bad++;
            $display("FAIL %s: got out=%b done=%b err=%b tail=%b, want out=%b done=%b err=%b tail=%b",
                     nm, frac_logic_out, cfg_done, cfg_err, ccff_tail,
                     x.out, x.done, x.err, x.tail);
        end
    endtask

    task automatic expect_now(input string nm, input logic [1:0] o, input logic d,
                              input logic e, input logic t);
        push(o, d, e, t);
        #1;
        check_pop(nm);
    endtask

    // All tasks are entered and left at a negedge (plus small offsets).
    task automatic do_reset();
        pReset = 1'b1;
        @(negedge prog_clk);
        pReset = 1'b0;
    endtask

    task automatic shift(input logic b);
        ccff_en   = 1'b1;
        ccff_head = b;
        @(negedge prog_clk);
        ccff_en   = 1'b0;
    endtask

    task automatic load(input logic [CB-1:0] c);
        for (int i = CB - 1; i >= 0; i--) shift(c[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{AND4,                   4'hF,    2'b11};
        vecs[1] = '{AND4,                   4'h7,    2'b10};
        vecs[2] = '{AND4,                   4'h0,    2'b00};
        vecs[3] = '{AND4,                   4'h8,    2'b00};
        vecs[4] = '{{3'b001, 16'h6996},     4'b0011, 2'b10};
        vecs[5] = '{{3'b000, 16'h6996},     4'b1011, 2'b11};
        vecs[6] = '{{3'b001, 16'h6996},     4'b1011, 2'b10};
        vecs[7] = '{{3'b000, 16'h6996},     4'b0001, 2'b01};
        vecs[8] = '{{3'b000, 16'h00FF},     4'b1101, 2'b00};
        vecs[9] = '{{3'b001, 16'hFF00},     4'b0010, 2'b10};

        @(negedge prog_clk);
        do_reset();
        expect_now("reset_state", 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge prog_clk);
        expect_now("reset_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Combinational vectors
        for (int i = 0; i < 10; i++) begin
            do_reset();
            frac_logic_in = '0;
            load(vecs[i].cfg);
            frac_logic_in = vecs[i].in;
            expect_now($sformatf("vec%0d", i), vecs[i].out, 1'b1, 1'b0, vecs[i].cfg[CB-1]);
        end

        // Registered outputs: one-cycle capture, then hold
        do_reset();
        load(AND4_R);
        frac_logic_in = 4'hF;
        expect_now("reg_before_capture", 2'b00, 1'b1, 1'b0, 1'b1);
        ff_en = 1'b1;
        expect_now("reg_same_cycle", 2'b00, 1'b1, 1'b0, 1'b1);
        push(2'b11, 1'b1, 1'b0, 1'b1);
        @(negedge prog_clk);
        ff_en = 1'b0;
        #1;
        check_pop("reg_captured");
        frac_logic_in = 4'h0;
        expect_now("reg_hold_in_change", 2'b11, 1'b1, 1'b0, 1'b1);
        @(negedge prog_clk);
        expect_now("reg_hold_next_cycle", 2'b11, 1'b1, 1'b0, 1'b1);

        // Paused load, completion on 19th shift, over-shift error
        do_reset();
        frac_logic_in = 4'hF;
        for (int i = CB - 1; i >= 9; i--) shift(AND4[i]);
        for (int p = 0; p < 5; p++) begin
            @(negedge prog_clk);
            expect_now($sformatf("pause%0d", p), 2'b00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 8; i >= 1; i--) shift(AND4[i]);
        expect_now("after_18_shifts", 2'b00, 1'b0, 1'b0, 1'b0);
        shift(AND4[0]);
        expect_now("after_19_shifts", 2'b11, 1'b1, 1'b0, 1'b0);
        shift(1'b0);
        expect_now("over_shift", 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge prog_clk);
        expect_now("error_sticky", 2'b00, 1'b0, 1'b1, 1'b0);

        // Reset during shift 10 wins over the shift
        do_reset();
        for (int i = 0; i < 9; i++) shift(1'b1);
        ccff_en = 1'b1; ccff_head = 1'b1; pReset = 1'b1;
        @(negedge prog_clk);
        ccff_en = 1'b0; pReset = 1'b0;
        expect_now("reset_during_shift", 2'b00, 1'b0, 1'b0, 1'b0);
        // A cleared chain shifts out only zeros, and a zeroed counter needs all 19 shifts.
        for (int i = 0; i < CB - 1; i++) shift(1'b0);
        expect_now("post_reset_18_zero", 2'b00, 1'b0, 1'b0, 1'b0);
        shift(1'b0);
        expect_now("post_reset_19_done", 2'b00, 1'b1, 1'b0, 1'b0);

        // Shift and ff_en together while configured
        do_reset();
        load(AND4_R);
        frac_logic_in = 4'hF;
        ff_en = 1'b1;
        shift(1'b0);
        ff_en = 1'b0;
        expect_now("shift_with_ff_en", 2'b00, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
